// File: rtl/jtag_host_shifter.sv
// JTAG host shifter: runs DR/IR scans and TAP resets as TCK bit sequences that
// start and end in Run-Test/Idle, all timed from CLOCK_50.
module jtag_host_shifter #(
    parameter int TCK_HALF = 2,
    parameter int MAX_LEN  = 32
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               cmd_ready,
    output logic               rsp_done,
    output logic               rsp_err,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               jtag_tck,
    output logic               jtag_tms,
    output logic               jtag_tdi,
    input  logic               jtag_tdo
);

    localparam int HW     = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
    localparam int BW_RAW = $clog2(MAX_LEN + 7);
    localparam int BW     = (BW_RAW > 7) ? BW_RAW : 7;
    localparam logic [HW-1:0] HALF_LAST = HW'(TCK_HALF - 1);
    localparam logic [6:0]    LEN_MAX   = 7'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t             state_q, state_n;
    logic [HW-1:0]      half_q, half_n;
    logic [BW-1:0]      bit_q, bit_n;
    logic [BW-1:0]      start_q, start_n;
    logic [BW-1:0]      end_q, end_n;
    logic [BW-1:0]      last_q, last_n;
    logic               is_reset_q, is_reset_n;
    logic               is_ir_q, is_ir_n;
    logic [5:0]         len_q, len_n;
    logic [MAX_LEN-1:0] tx_q, tx_n;
    logic [MAX_LEN-1:0] rx_q, rx_n;
    logic [MAX_LEN-1:0] rsp_q, rsp_n;
    logic               tck_q, tck_n;
    logic               tms_q, tms_n;
    logic               tdi_q, tdi_n;
    logic               ready_q, ready_n;
    logic               done_q, done_n;
    logic               err_q, err_n;
    logic               tdo_s1, tdo_s2;

    logic [BW-1:0] nxt_bit;
    logic          cur_shift, nxt_shift, nxt_tms, reject;
    logic [BW-1:0] acc_start, acc_end;

    // Shift bits occupy [start_q, end_q); the two bits after them exit via Exit1/Update.
    always_comb begin
        nxt_bit   = bit_q + BW'(1);
        cur_shift = !is_reset_q && (bit_q >= start_q) && (bit_q < end_q);
        nxt_shift = !is_reset_q && (nxt_bit >= start_q) && (nxt_bit < end_q);
        if (is_reset_q) begin
            nxt_tms = (nxt_bit < BW'(5));
        end else begin
            nxt_tms = (nxt_bit < (is_ir_q ? BW'(2) : BW'(1)))
                   || (nxt_bit == end_q - BW'(1))
                   || (nxt_bit == end_q);
        end
        reject    = (cmd_op == 2'b11)
                 || ((cmd_op != 2'b10) && ((cmd_len == '0) || ({1'b0, cmd_len} > LEN_MAX)));
        acc_start = (cmd_op == 2'b01) ? BW'(4) : BW'(3);
        acc_end   = acc_start + BW'(cmd_len);
    end

    always_comb begin
        state_n    = state_q;
        half_n     = half_q;
        bit_n      = bit_q;
        start_n    = start_q;
        end_n      = end_q;
        last_n     = last_q;
        is_reset_n = is_reset_q;
        is_ir_n    = is_ir_q;
        len_n      = len_q;
        tx_n       = tx_q;
        rx_n       = rx_q;
        rsp_n      = rsp_q;
        tck_n      = tck_q;
        tms_n      = tms_q;
        tdi_n      = tdi_q;
        ready_n    = ready_q;
        done_n     = 1'b0;
        err_n      = 1'b0;

        case (state_q)
            IDLE: begin
                ready_n = 1'b1;
                tck_n   = 1'b0;
                tms_n   = 1'b0;
                tdi_n   = 1'b0;
            end
            LOW: begin
                if (half_q == HALF_LAST) begin
                    state_n = HIGH;
                    half_n  = '0;
                    tck_n   = 1'b1;
                end else begin
                    half_n = half_q + HW'(1);
                end
            end
            HIGH: begin
                if (half_q == HALF_LAST) begin
                    half_n = '0;
                    tck_n  = 1'b0;
                    if (cur_shift) begin
                        rx_n = {tdo_s2, rx_q[MAX_LEN-1:1]};
                    end
                    if (bit_q == last_q) begin
                        state_n = DONE;
                        tms_n   = 1'b0;
                        tdi_n   = 1'b0;
                        done_n  = 1'b1;
                        ready_n = 1'b1;
                        // Captured bits arrive MSB-first into rx_q; right-align to bit 0.
                        rsp_n   = is_reset_q ? '0 : (rx_q >> (MAX_LEN - int'(len_q)));
                    end else begin
                        state_n = LOW;
                        bit_n   = nxt_bit;
                        tms_n   = nxt_tms;
                        if (nxt_shift) begin
                            tdi_n = tx_q[0];
                            tx_n  = tx_q >> 1;
                        end else begin
                            tdi_n = 1'b0;
                        end
                    end
                end else begin
                    half_n = half_q + HW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        if (cmd_valid && ready_q) begin
            tck_n = 1'b0;
            tdi_n = 1'b0;
            if (reject) begin
                state_n = DONE;
                tms_n   = 1'b0;
                done_n  = 1'b1;
                err_n   = 1'b1;
                ready_n = 1'b1;
            end else begin
                state_n    = LOW;
                ready_n    = 1'b0;
                half_n     = '0;
                bit_n      = '0;
                tms_n      = 1'b1;
                is_reset_n = (cmd_op == 2'b10);
                is_ir_n    = (cmd_op == 2'b01);
                len_n      = cmd_len;
                start_n    = acc_start;
                end_n      = acc_end;
                last_n     = (cmd_op == 2'b10) ? BW'(5) : acc_end + BW'(1);
                tx_n       = cmd_data;
                rx_n       = '0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            half_q     <= '0;
            bit_q      <= '0;
            start_q    <= '0;
            end_q      <= '0;
            last_q     <= '0;
            is_reset_q <= 1'b0;
            is_ir_q    <= 1'b0;
            len_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rsp_q      <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_n;
            half_q     <= half_n;
            bit_q      <= bit_n;
            start_q    <= start_n;
            end_q      <= end_n;
            last_q     <= last_n;
            is_reset_q <= is_reset_n;
            is_ir_q    <= is_ir_n;
            len_q      <= len_n;
            tx_q       <= tx_n;
            rx_q       <= rx_n;
            rsp_q      <= rsp_n;
            tck_q      <= tck_n;
            tms_q      <= tms_n;
            tdi_q      <= tdi_n;
            ready_q    <= ready_n;
            done_q     <= done_n;
            err_q      <= err_n;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tdo_s1 <= 1'b0;
            tdo_s2 <= 1'b0;
        end else begin
            tdo_s1 <= jtag_tdo;
            tdo_s2 <= tdo_s1;
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_done  = done_q;
    assign rsp_err   = err_q;
    assign rsp_data  = rsp_q;
    assign jtag_tck  = tck_q;
    assign jtag_tms  = tms_q;
    assign jtag_tdi  = tdi_q;

endmodule

// File: tb/tb_jtag_host_shifter.sv
// Directed bench for jtag_host_shifter: scoreboarded TMS/TDI streams and responses
// against a TAP-side TDO model (echo of previous TDI, or tied high).
module tb_jtag_host_shifter;

    localparam int TCK_HALF = 2;
    localparam int MAX_LEN  = 32;

    logic               CLOCK_50 = 1'b0;
    logic               reset    = 1'b1;
    logic               cmd_valid = 1'b0;
    logic [1:0]         cmd_op    = '0;
    logic [5:0]         cmd_len   = '0;
    logic [MAX_LEN-1:0] cmd_data  = '0;
    logic               cmd_ready, rsp_done, rsp_err;
    logic [MAX_LEN-1:0] rsp_data;
    logic               jtag_tck, jtag_tms, jtag_tdi, jtag_tdo;

    jtag_host_shifter #(.TCK_HALF(TCK_HALF), .MAX_LEN(MAX_LEN)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd_op   (cmd_op),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .cmd_ready(cmd_ready),
        .rsp_done (rsp_done),
        .rsp_err  (rsp_err),
        .rsp_data (rsp_data),
        .jtag_tck (jtag_tck),
        .jtag_tms (jtag_tms),
        .jtag_tdi (jtag_tdi),
        .jtag_tdo (jtag_tdo)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Target model: TDO presents the TDI captured on the previous TCK rising edge.
    logic tdo_mode = 1'b0;
    logic tdo_reg  = 1'b0;
    always @(posedge jtag_tck) tdo_reg <= jtag_tdi;
    assign jtag_tdo = tdo_mode ? 1'b1 : tdo_reg;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          pulses;
    } rsp_t;

    int   checks = 0;
    int   fails  = 0;
    logic exp_tms[$];
    logic exp_tdi[$];
    rsp_t exp_rsp[$];
    rsp_t r;

    int   pulses    = 0;
    int   done_cnt  = 0;
    int   cyc       = 0;
    int   last_rise = 0;
    logic rise_seen = 1'b0;
    logic prev_tck  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_bit(input logic t, input logic d);
        exp_tms.push_back(t);
        exp_tdi.push_back(d);
    endtask

    task automatic push_seq(input logic [1:0] op, input int len, input logic [31:0] data);
        logic [31:0] d;
        d = data;
        if (op == 2'b10) begin
            for (int i = 0; i < 5; i++) push_bit(1'b1, 1'b0);
            push_bit(1'b0, 1'b0);
        end else begin
            push_bit(1'b1, 1'b0);
            if (op == 2'b01) push_bit(1'b1, 1'b0);
            push_bit(1'b0, 1'b0);
            push_bit(1'b0, 1'b0);
            for (int k = 0; k < len; k++) push_bit(k == len - 1, d[k]);
            push_bit(1'b1, 1'b0);
            push_bit(1'b0, 1'b0);
        end
    endtask

    // Monitor: TCK shape, per-pulse TMS/TDI, and responses against the scoreboard.
    always @(negedge CLOCK_50) begin
        if (reset) begin
            prev_tck  = 1'b0;
            rise_seen = 1'b0;
            pulses    = 0;
        end else begin
            if (cmd_ready) rise_seen = 1'b0;
            if (jtag_tck && !prev_tck) begin
                pulses++;
                check("pulse_expected", exp_tms.size() > 0, 1);
                if (exp_tms.size() > 0) begin
                    check("tms", jtag_tms, exp_tms.pop_front());
                    check("tdi", jtag_tdi, exp_tdi.pop_front());
                end
                if (rise_seen) check("tck_period", cyc - last_rise, 2 * TCK_HALF);
                last_rise = cyc;
                rise_seen = 1'b1;
            end
            if (!jtag_tck && prev_tck) check("tck_high", cyc - last_rise, TCK_HALF);
            prev_tck = jtag_tck;
            if (rsp_done) begin
                done_cnt++;
                check("rsp_expected", exp_rsp.size() > 0, 1);
                if (exp_rsp.size() > 0) begin
                    r = exp_rsp.pop_front();
                    check("rsp_err", rsp_err, r.err);
                    check("rsp_data", rsp_data, r.data);
                    check("pulse_count", pulses, r.pulses);
                    check("tms_leftover", exp_tms.size(), 0);
                end
                pulses = 0;
            end
        end
        cyc++;
    end

    task automatic send(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                        input logic err, input logic [31:0] edata, input int epulses);
        int n;
        int start_done;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        if (!err) push_seq(op, int'(len), data);
        exp_rsp.push_back('{err, edata, epulses});
        start_done = done_cnt;
        @(negedge CLOCK_50);
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_len   = ~len;
        cmd_data  = ~data;
        if (err) begin
            check("rej_done", rsp_done, 1);
            check("rej_err", rsp_err, 1);
            check("rej_tck", jtag_tck, 0);
        end else begin
            check("busy_ready", cmd_ready, 0);
        end
        n = 0;
        while (done_cnt == start_done && n < 2000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("done_timeout", done_cnt != start_done, 1);
    endtask

    initial begin
        int n;
        int busy_ready;
        int saved_done;
        logic [31:0] d20;

        repeat (3) @(negedge CLOCK_50);
        check("rst_tck", jtag_tck, 0);
        check("rst_tms", jtag_tms, 1);
        check("rst_tdi", jtag_tdi, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_done", rsp_done, 0);
        check("rst_data", rsp_data, 0);
        reset = 1'b0;
        @(posedge CLOCK_50);
        #1;
        check("post_rst_tms", jtag_tms, 0);
        check("post_rst_ready", cmd_ready, 1);
        check("idle_tck", jtag_tck, 0);
        check("idle_tdi", jtag_tdi, 0);
        @(negedge CLOCK_50);

        send(2'b10, 6'd0,  32'h0000_0000, 1'b0, 32'h0000_0000, 6);
        send(2'b00, 6'd8,  32'h0000_00A5, 1'b0, 32'h0000_004A, 13);
        send(2'b00, 6'd0,  32'h0000_1234, 1'b1, 32'h0000_004A, 0);
        send(2'b11, 6'd4,  32'h0000_000F, 1'b1, 32'h0000_004A, 0);
        send(2'b01, 6'd2,  32'h0000_0002, 1'b0, 32'h0000_0000, 8);
        tdo_mode = 1'b1;
        send(2'b00, 6'd1,  32'h0000_0000, 1'b0, 32'h0000_0001, 6);
        send(2'b00, 6'd32, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 37);
        send(2'b01, 6'd33, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 0);
        tdo_mode = 1'b0;
        send(2'b00, 6'd12, 32'h0000_0C3F, 1'b0, 32'h0000_087E, 17);

        @(negedge CLOCK_50);
        d20 = $urandom & 32'h000F_FFFF;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_len   = 6'd20;
        cmd_data  = d20;
        push_seq(2'b00, 20, d20);
        exp_rsp.push_back('{1'b0, 32'h0, 25});
        @(negedge CLOCK_50);
        busy_ready = 0;
        n = 0;
        while (pulses < 5 && n < 500) begin
            @(negedge CLOCK_50);
            n++;
            if (cmd_ready) busy_ready++;
        end
        check("pulse5_timeout", pulses >= 5, 1);
        check("no_accept_busy", busy_ready, 0);
        saved_done = done_cnt;
        reset = 1'b1;
        #1;
        exp_rsp.delete();
        exp_tms.delete();
        exp_tdi.delete();
        cmd_valid = 1'b0;
        check("abort_tck", jtag_tck, 0);
        check("abort_tms", jtag_tms, 1);
        check("abort_tdi", jtag_tdi, 0);
        check("abort_ready", cmd_ready, 0);
        check("abort_done", rsp_done, 0);
        check("abort_err", rsp_err, 0);
        check("abort_data", rsp_data, 0);
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        @(posedge CLOCK_50);
        #1;
        check("abort_post_tms", jtag_tms, 0);
        check("abort_post_ready", cmd_ready, 1);
        repeat (20) @(negedge CLOCK_50);
        check("abort_no_done", done_cnt, saved_done);

        send(2'b10, 6'd0, 32'h0000_0000, 1'b0, 32'h0000_0000, 6);
        repeat (3) @(negedge CLOCK_50);
        check("final_idle_tms", jtag_tms, 0);
        check("final_idle_tck", jtag_tck, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/jtag_host_shifter.md
JTAG_HOST_SHIFTER -- requirements
Module: jtag_host_shifter

Interface
REQ-001 Parameter: TCK_HALF, default 2, number of CLOCK_50 cycles per TCK half-period (legal range 1..255).
REQ-002 Parameter: MAX_LEN, default 32, maximum scan length in bits.
REQ-003 CLOCK_50  input  1  the only clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  a command is presented.
REQ-006 cmd_op  input  2  operation: 00 DR scan, 01 IR scan, 10 TAP reset, 11 reserved.
REQ-007 cmd_len  input  6  scan length in bits, 1..MAX_LEN; ignored for TAP reset.
REQ-008 cmd_data  input  MAX_LEN  bits to shift out, LSB first.
REQ-009 cmd_ready  output  1  high when idle and able to accept a command.
REQ-010 rsp_done  output  1  one-cycle pulse when a command completes.
REQ-011 rsp_err  output  1  valid with rsp_done; 1 means the command was rejected.
REQ-012 rsp_data  output  MAX_LEN  captured TDO bits, valid from rsp_done until the next accept.
REQ-013 jtag_tck, jtag_tms, jtag_tdi  output  1 each  drive the target TAP, for example a board running a Virtual JTAG responder.
REQ-014 jtag_tdo  input  1  TDO from the target; SHALL be passed through a 2-flop synchronizer before use.

Function
REQ-015 A command SHALL be accepted on a cycle where cmd_valid and cmd_ready are both 1; cmd_op, cmd_len and cmd_data SHALL be latched on that cycle.
REQ-016 cmd_ready SHALL fall on the cycle after an accept and rise on the same cycle as rsp_done.
REQ-017 cmd_valid SHALL be ignored while cmd_ready is 0.
REQ-018 A command with cmd_op=11, or with cmd_len=0 or cmd_len>MAX_LEN on a scan op, SHALL be rejected: no TCK edges, rsp_done=1 and rsp_err=1 on the cycle after accept, rsp_data unchanged.
REQ-019 States: IDLE, LOW, HIGH, DONE. Each TCK bit SHALL consist of one LOW phase (jtag_tck=0) of TCK_HALF cycles followed by one HIGH phase (jtag_tck=1) of TCK_HALF cycles.
REQ-020 jtag_tms and jtag_tdi SHALL change only on entry to LOW; TDO SHALL be sampled (synchronized value) on the last CLOCK_50 cycle of HIGH.
REQ-021 The TMS sequence per TCK bit, with the target starting in Run-Test/Idle, SHALL be:
- DR scan: 1,0,0, then cmd_len shift bits, then 1,0.
- IR scan: 1,1,0,0, then cmd_len shift bits, then 1,0.
- TAP reset: 1,1,1,1,1,0.
REQ-022 Within the shift bits, TMS SHALL be 0 except on the last shift bit, where it SHALL be 1 (exit to Exit1).
REQ-023 Total TCK pulses SHALL be: cmd_len+5 for DR, cmd_len+6 for IR, 6 for TAP reset.
REQ-024 During shift bit k (0-based), jtag_tdi SHALL equal cmd_data[k]; outside shift bits, jtag_tdi SHALL be 0.
REQ-025 The TDO sampled during shift bit k SHALL be stored in rsp_data[k]; rsp_data bits at index cmd_len and above SHALL be 0; a TAP reset SHALL leave rsp_data at all zeros.
REQ-026 After the final HIGH phase, the block SHALL drive jtag_tck=0, enter DONE for one cycle (rsp_done=1, rsp_err=0), then return to IDLE.
REQ-027 In IDLE, jtag_tck SHALL be 0, jtag_tms SHALL be 0, and jtag_tdi SHALL be 0.
REQ-028 Counters SHALL be sized for MAX_LEN+6 bits and TCK_HALF; no counter SHALL wrap during a legal command.
REQ-029 A single-bit scan (cmd_len=1) SHALL assert TMS=1 on its only shift bit.

Reset
REQ-030 While reset=1, the block SHALL immediately be in IDLE with outputs as follows:
- jtag_tck=0, jtag_tms=1, jtag_tdi=0
- cmd_ready=0, rsp_done=0, rsp_err=0, rsp_data=0
- synchronizer flops cleared
REQ-031 On the first cycle after reset falls, jtag_tms SHALL be 0 and cmd_ready SHALL be 1.
REQ-032 Reset asserted mid-command SHALL abort the command without rsp_done; the target TAP state is then undefined until a TAP reset command is issued.

Verification
REQ-033 TAP reset, TCK_HALF=2 -> exactly 6 TCK pulses, each 4 CLOCK_50 cycles long, TMS=1,1,1,1,1,0, then rsp_done with rsp_err=0 and rsp_data=0.
REQ-034 DR scan, len=8, data=0xA5, with a TDO model returning the TDI from one TCK earlier (1-bit register, initially 0) -> 13 TCK pulses, TDI shift stream 1,0,1,0,0,1,0,1, rsp_data=0x4A.
REQ-035 IR scan, len=2, data=2'b10 -> TMS=1,1,0,0,0,1,1,0, 8 pulses, TDI=0 then 1 on the shift bits.
REQ-036 Reject cases: cmd_len=0 or cmd_op=11 -> rsp_done and rsp_err pulse on the cycle after accept, jtag_tck stays 0.
REQ-037 cmd_valid held high during a busy scan, then reset asserted at pulse 5 -> no second accept while busy; after reset, outputs match REQ-030 and no rsp_done is issued for the aborted command.
REQ-038 DR scan, len=32, data=0xFFFFFFFF, TDO tied to 1 -> 37 pulses, rsp_data=0xFFFFFFFF, last shift bit has TMS=1.
